// File: rtl/adder_32_bit_pkg.sv
// rtl/adder_32_bit_pkg.sv - shared width constant and word type for the registered adder
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_pkg

// File: rtl/adder_32_bit_if.sv
// rtl/adder_32_bit_if.sv - operand/result bundle for adder_32_bit; zero flag present with ADDER_ZERO_FLAG_EN
interface adder_32_bit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             carryin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
`ifdef ADDER_ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output in_valid,
        output input1,
        output input2,
        output carryin,
        input  out_valid,
        input  sum,
        input  carryout,
`ifdef ADDER_ZERO_FLAG_EN
        input  zero,
`endif
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  input1,
        input  input2,
        input  carryin,
        output out_valid,
        output sum,
        output carryout,
`ifdef ADDER_ZERO_FLAG_EN
        output zero,
`endif
        output overflow
    );

endinterface : adder_32_bit_if

// File: rtl/adder_32_bit_full_adder.sv
// rtl/adder_32_bit_full_adder.sv - combinational 1-bit full adder cell of the ripple chain
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/adder_32_bit.sv
// rtl/adder_32_bit.sv - registered ripple-carry adder, 1-cycle latency; optional zero flag via ADDER_ZERO_FLAG_EN
module adder_32_bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_32_bit_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carryout_q;
    logic             overflow_q;

    assign carry[0] = bus.carryin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1bit u_fa (
            .a    (bus.input1[i]),
            .b    (bus.input2[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers only load on a valid strobe so idle cycles never disturb them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q      <= sum_comb;
                carryout_q <= carry[WIDTH];
                overflow_q <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;

`ifdef ADDER_ZERO_FLAG_EN
    logic zero_q;

    // Cleared on reset even though the reset sum is zero, matching the other flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (bus.in_valid) begin
            zero_q <= (sum_comb == '0);
        end
    end

    assign bus.zero = zero_q;
`endif

endmodule : adder_32_bit

// File: tb/tb_adder_32_bit.sv
// tb/tb_adder_32_bit.sv - self-checking bench for adder_32_bit (zero flag checked when ADDER_ZERO_FLAG_EN)
module tb_adder_32_bit;
    import adder_pkg::*;

    typedef struct {
        word_t a;
        word_t b;
        logic  ci;
        word_t s;
        logic  co;
        logic  ov;
        logic  z;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    adder_32_bit_if #(.WIDTH(ADDER_WIDTH)) bus ();

    adder_32_bit #(.WIDTH(ADDER_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input word_t s,
                           input logic co, input logic ov, input logic z);
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, " sum"},       bus.sum, s);
        chk({tag, " carryout"},  {31'd0, bus.carryout}, {31'd0, co});
        chk({tag, " overflow"},  {31'd0, bus.overflow}, {31'd0, ov});
`ifdef ADDER_ZERO_FLAG_EN
        chk({tag, " zero"},      {31'd0, bus.zero}, {31'd0, z});
`else
        if (z === 1'bx) $display("unexpected X on expected zero for %s", tag);
`endif
    endtask

    // Drive on the falling edge, let one rising edge capture, sample on the next falling edge.
    task automatic cyc(input logic r, input logic v, input word_t a, input word_t b, input logic ci);
        rst_n        = r;
        bus.in_valid = v;
        bus.input1   = a;
        bus.input2   = b;
        bus.carryin  = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.input1   = '0;
        bus.input2   = '0;
        bus.carryin  = 1'b0;

        vecs[0] = '{32'd1,        32'd3,        1'b0, 32'd4,        1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd1,        32'd3,        1'b1, 32'd5,        1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};

        @(negedge clk);

        // Reset held two cycles with a valid operand pair present.
        cyc(1'b0, 1'b1, 32'd5, 32'd6, 1'b0);
        chk_all("reset1", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd5, 32'd6, 1'b0);
        chk_all("reset2", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
            chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z);
        end

        // Idle after an overflowing add: flags and sum must hold.
        cyc(1'b1, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0);
        chk_all("ovf_src", 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        chk_all("ovf_hold", 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream then idle with changed operands.
        cyc(1'b1, 1'b1, 32'd2, 32'd2, 1'b0);
        chk_all("stream1", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'd10, 32'd20, 1'b0);
        chk_all("stream2", 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'd7, 32'd7, 1'b0);
        chk_all("idle1", 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'd7, 32'd7, 1'b0);
        chk_all("idle2", 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

        // Zero result held across idle.
        cyc(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk_all("zero_src", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'd3, 32'd3, 1'b0);
        chk_all("zero_hold", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

        // Reset coinciding with a valid operand pair discards it.
        cyc(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk_all("pre_rst", 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'd100, 32'd200, 1'b0);
        chk_all("mid_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'd1, 32'd1, 1'b0);
        chk_all("post_rst", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        chk_all("post_idle", 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_adder_32_bit

// File: doc/adder_32_bit.md
Name: adder_32_bit

Overview:
- Registered 32-bit binary adder with carry-in, carry-out and signed-overflow flag.
- Datapath primitive for the MIPS ALU and PC-increment paths.
- Operands are captured with a valid strobe; the result appears one clock later.
- Internally a ripple-carry chain of 1-bit full adders.

Parameters:
- WIDTH, 32, operand/sum width in bits. Only 32 is required to be supported; other values need not be verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid this cycle
- input1  input  WIDTH  operand A (unsigned or two's complement)
- input2  input  WIDTH  operand B
- carryin  input  1  carry into bit 0
- out_valid  output  1  sum/flags valid
- sum  output  WIDTH  registered (input1 + input2 + carryin) mod 2^WIDTH
- carryout  output  1  registered carry out of bit WIDTH-1 (unsigned overflow)
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  only present with ADDER_ZERO_FLAG_EN; registered, high when sum == 0

Behaviour:
- Reset: one clock and synchronous active-low reset, sampled on the clk rising edge; when rst_n=0 at the edge, out_valid, sum, carryout, overflow (and zero) all clear to 0.
  - Reset overrides a simultaneous in_valid.
  - Reset mid-operation discards the in-flight result.
- Latency: exactly 1 cycle. If in_valid=1 at edge N (rst_n=1), the result is visible after edge N and out_valid=1 for that cycle.
- out_valid is a registered copy of in_valid; no backpressure and no ready signal. Back-to-back in_valid gives a result every cycle.
- When in_valid=0 at an edge: out_valid goes 0; sum/carryout/overflow/zero hold their previous values (no toggling on idle).
- Arithmetic: full WIDTH+1-bit result {carryout,sum} = input1 + input2 + carryin. No saturation; wrap-around modulo 2^32.
- overflow is computed as c[WIDTH-1] XOR c[WIDTH]. Example: 0x7FFFFFFF+1 sets overflow=1, carryout=0.
- Combinational path: a generate loop of WIDTH full_adder_1bit instances chained c[i]→c[i+1], c[0]=carryin. Outputs are registered only at the chain end.
- No X propagation from an idle path: operands are not registered when in_valid=0.

Optional Feature:
- Macro ADDER_ZERO_FLAG_EN.
- Defined: adds the zero output port, registered with the same timing and hold/reset rules as sum (reset value 0, even though reset sum is 0).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package adder_pkg holds the ADDER_WIDTH constant (32) and the typedef word_t (logic [ADDER_WIDTH-1:0]).
- One sub-module, full_adder_1bit: inputs a, b, cin; outputs s, cout; purely combinational (s = a^b^cin, cout = majority).
- The top instantiates WIDTH copies plus the output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, input1=5, input2=6 -> out_valid=0, sum=0, carryout=0, overflow=0 throughout.
- Basic: in_valid=1, input1=1, input2=3, carryin=0 -> next cycle sum=4, carryout=0, overflow=0, out_valid=1. Then carryin=1, same operands -> sum=5.
- Unsigned wrap: input1=0xFFFFFFFF, input2=0x00000001, carryin=0 -> sum=0x00000000, carryout=1, overflow=0 (zero=1 if enabled).
- Signed overflow: input1=0x7FFFFFFF, input2=1 -> sum=0x80000000, carryout=0, overflow=1. Also 0x80000000+0x80000000 -> sum=0, carryout=1, overflow=1.
- Hold/streaming: back-to-back valid pairs (2+2, 10+20) -> sums 4 then 30 on consecutive cycles. Then in_valid=0 with operands changed to 7+7 -> out_valid=0, sum stays 30.
- Reset mid-stream: in_valid=1 (100+200) at the same edge as rst_n=0 -> next cycle out_valid=0, sum=0. After release with in_valid=1 (1+1) -> sum=2 one cycle later.
